cacheline_adaptor: RTL
======================

Name: cacheline_adaptor

Overview:
- Sits between the data cache controller/datapath and physical memory.
- Converts one 256-bit cacheline transfer into a 4-beat 64-bit burst on the memory side, in both read and write directions.
- Line side uses the cache's hold-until-response pmem handshake.
- Memory side uses a level request with a per-beat response strobe.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory beat width in bits.
- ADDR_W, 32, address width.
- BEATS = LINE_W/BURST_W (4) is derived, not overridable.
- OFFSET = log2(LINE_W/8) (5) is derived, not overridable.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- line_i  in  LINE_W  line to write back, from the cache datapath.
- line_o  out  LINE_W  assembled line returned to the cache.
- address_i  in  ADDR_W  line address from the cache.
- read_i  in  1  cache pmem_read.
- write_i  in  1  cache pmem_write.
- resp_o  out  1  cache pmem_resp.
- burst_i  in  BURST_W  memory read beat.
- burst_o  out  BURST_W  memory write beat.
- address_o  out  ADDR_W  line-aligned memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat strobe.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat counter=0.
  - line buffer=0, address register=0.
  - resp_o, read_o and write_o are 0; burst_o=0; line_o=0.
  - Takes effect mid-burst: an in-flight burst is abandoned and no resp_o is issued.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1: latch address_i and line_i, counter=0, go to WRITE.
  - Else read_i=1: latch address_i, counter=0, go to READ.
  - write_i has priority if both are high; both high is a protocol violation by the cache and is not otherwise flagged.
  - resp_i in IDLE is ignored.
- address_o = {latched address[ADDR_W-1:OFFSET], OFFSET'b0}. It is stable for the whole burst and never exposes the raw cache address combinationally.
- READ:
  - read_o=1.
  - Each cycle with resp_i=1: buffer slice [counter*64 +: 64] <= burst_i, counter++.
  - On the beat where counter==BEATS-1: go to DONE, drop read_o from the next cycle.
  - Beats are little-endian: beat 0 is line bits [63:0].
- WRITE:
  - write_o=1, burst_o = latched line slice [counter*64 +: 64] (combinational from counter).
  - resp_i=1 means the beat is consumed; counter++.
  - After beat BEATS-1: go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle, then go to IDLE.
  - Holds for reads and writes.
- line_o is driven from the buffer at all times. It holds the last completed read line until the next read's first beat overwrites slice 0. The cache samples line_o only in the resp_o cycle.
- Latency, request in IDLE to resp_o:
  - 1 cycle to accept the request.
  - One cycle per beat while resp_i is high (4 beats minimum).
  - 1 cycle in DONE.
  - Minimum total: request at cycle 0, resp_o at cycle 5.
- resp_i gaps (stalls) are allowed mid-burst; the counter holds.
- Counter width is log2(BEATS); it wraps to 0 on entering DONE.
- Back-to-back requests:
  - The cache drops the request after resp_o, so IDLE re-accepts on the following cycle.
  - Write-back followed by read-back (dirty miss) needs no idle bubble beyond DONE→IDLE.
- Request deassertion mid-burst is not supported; the burst completes regardless.

Decomposition:
- Shared package cacheline_adaptor_pkg:
  - State enum type.
  - Localparams: LINE_W, BURST_W, BEATS, OFFSET.
- Sub-module: none; the whole block is a single FSM plus a datapath.
- An optional cla_beat_buffer (shift/slice register with counter) is acceptable but not required.

Test Plan:
- Read, no stalls:
  - Stimulus: read_i=1, address_i=0x0000_1234; memory supplies beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on consecutive cycles.
  - Required: address_o=0x0000_1220; resp_o=1 at cycle 5; line_o = {0x4444..., 0x3333..., 0x2222..., 0x1111...}; read_o low after beat 4.
- Write, 2-cycle gap after beat 1:
  - Stimulus: line_i = {64'hD, 64'hC, 64'hB, 64'hA}.
  - Required: burst_o shows A, B, C, D in order; counter holds during the gap; resp_o single pulse at cycle 7.
- Dirty miss sequence:
  - Stimulus: write then read, with read_i asserted the cycle after resp_o.
  - Required: write_o and read_o never high together; address_o updates to the read address; both resp_o pulses are exactly 1 cycle.
- Reset mid-read:
  - Stimulus: rst=0 after beat 2.
  - Required: read_o, resp_o and line_o are 0 immediately; a subsequent read completes normally with all 4 new beats.
- Simultaneous read_i and write_i in IDLE:
  - Required: WRITE serviced (write_o=1, read_o=0).
- resp_i pulsed in IDLE with no request:
  - Required: no state change, resp_o stays 0.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default geometry for the cacheline/burst adaptor.
package cacheline_adaptor_pkg;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BURST_W = 64;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BEATS   = LINE_W / BURST_W;
    localparam int unsigned OFFSET  = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one cacheline transfer into a little-endian multi-beat memory burst,
// in both read and write directions, behind the cache's hold-until-response
// pmem handshake.
module cacheline_adaptor
    import cacheline_adaptor_pkg::state_e;
#(
    parameter int unsigned LINE_W  = cacheline_adaptor_pkg::LINE_W,
    parameter int unsigned BURST_W = cacheline_adaptor_pkg::BURST_W,
    parameter int unsigned ADDR_W  = cacheline_adaptor_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,

    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned BEATS  = LINE_W / BURST_W;
    localparam int unsigned OFFSET = $clog2(LINE_W / 8);
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFFSET){1'b1}}, {OFFSET{1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wr_line_q;
    logic [LINE_W-1:0]   rd_line_q;
    logic                last_beat;

    assign last_beat = (cnt_q == LAST_BEAT);

    // Masking the latched address keeps the memory address line-aligned and
    // stable for the whole burst, independent of what the cache drives later.
    assign address_o = addr_q & ALIGN_MASK;

    // Write data lives in its own register so a write-back never disturbs the
    // last read line still visible on line_o.
    assign line_o = rd_line_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= cacheline_adaptor_pkg::IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state handshake outputs.
    always_comb begin
        state_d = state_q;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        unique case (state_q)
            cacheline_adaptor_pkg::IDLE: begin
                if (write_i) begin
                    state_d = cacheline_adaptor_pkg::WRITE;
                end else if (read_i) begin
                    state_d = cacheline_adaptor_pkg::READ;
                end
            end
            cacheline_adaptor_pkg::READ: begin
                read_o = 1'b1;
                if (resp_i && last_beat) begin
                    state_d = cacheline_adaptor_pkg::DONE;
                end
            end
            cacheline_adaptor_pkg::WRITE: begin
                write_o = 1'b1;
                burst_o = wr_line_q[cnt_q*BURST_W +: BURST_W];
                if (resp_i && last_beat) begin
                    state_d = cacheline_adaptor_pkg::DONE;
                end
            end
            cacheline_adaptor_pkg::DONE: begin
                resp_o  = 1'b1;
                state_d = cacheline_adaptor_pkg::IDLE;
            end
            default: begin
                state_d = cacheline_adaptor_pkg::IDLE;
            end
        endcase
    end

    // Request capture, beat counting and read-line assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_line_q <= '0;
            rd_line_q <= '0;
        end else begin
            unique case (state_q)
                cacheline_adaptor_pkg::IDLE: begin
                    if (write_i) begin
                        addr_q    <= address_i;
                        wr_line_q <= line_i;
                        cnt_q     <= '0;
                    end else if (read_i) begin
                        addr_q <= address_i;
                        cnt_q  <= '0;
                    end
                end
                cacheline_adaptor_pkg::READ: begin
                    if (resp_i) begin
                        rd_line_q[cnt_q*BURST_W +: BURST_W] <= burst_i;
                        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
                    end
                end
                cacheline_adaptor_pkg::WRITE: begin
                    if (resp_i) begin
                        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
